// File: rtl/parking_pkg.sv
// parking_pkg: shared state enum, time constants and the lowest-free-slot encoder.
package parking_pkg;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
   localparam int SECS_PER_MIN = 60;
   // Index of the lowest clear bit among the first n bits; 0 when none is clear.
   function automatic int lowest_free(input logic [15:0] occ, input int n);
      int idx = 0;
      for (int i = 15; i >= 0; i--) if (i < n && !occ[i]) idx = i;
      return idx;
   endfunction
endpackage

// File: rtl/slot_timer.sv
// slot_timer: per-slot stay timer, counts ticks while occupied and saturates at MAX_SECONDS.
module slot_timer #(
   parameter int MAX_SECONDS = 3599,
   parameter int W           = $clog2(MAX_SECONDS + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick_1hz,
   input  logic         occupied,
   input  logic         clear,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clear || !occupied) count <= '0;
      else if (tick_1hz && count != W'(MAX_SECONDS)) count <= count + 1'b1;
endmodule

// File: rtl/parking_manager.sv
// parking_manager: slot occupancy, capacity, first-free location and per-slot stay timers.
module parking_manager
   import parking_pkg::*;
#(
   parameter int NUM_SLOTS   = 4,
   parameter int MAX_SECONDS = 3599,
   parameter int SLOT_W      = $clog2(NUM_SLOTS),
   parameter int CAP_W       = $clog2(NUM_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_1hz,
   input  logic                 entry_signal,
   input  logic                 exit_signal,
   input  logic [SLOT_W-1:0]    exit_slot,
   output logic                 is_open,
   output logic                 is_full,
   output logic                 exit_err,
   output logic [NUM_SLOTS-1:0] spots,
   output logic [CAP_W-1:0]     capacity,
   output logic [SLOT_W-1:0]    location,
   output logic                 loc_valid,
   output logic                 exit_valid,
   output logic [5:0]           exit_minutes,
   output logic [5:0]           exit_seconds
);
   localparam int TW  = $clog2(MAX_SECONDS + 1);
   localparam int PAD = 1 << SLOT_W;
   state_t state, state_n;
   logic [PAD-1:0] spots_pad, exit_mask, entry_mask;
   logic [NUM_SLOTS-1:0] after_exit, spots_n;
   logic [CAP_W-1:0] capacity_n;
   logic [TW-1:0] timers [NUM_SLOTS];
   logic [TW-1:0] t_sel;
   logic exit_ok, entry_ok, has_free;

   // Exit is applied first so a simultaneous entry can reuse the vacated slot.
   always_comb begin
      spots_pad  = PAD'(spots);
      exit_ok    = exit_signal && spots_pad[exit_slot];
      exit_mask  = exit_ok ? PAD'(1) << exit_slot : '0;
      after_exit = spots & ~exit_mask[NUM_SLOTS-1:0];
      has_free   = ~&after_exit;
      entry_ok   = entry_signal && has_free;
      entry_mask = entry_ok ? PAD'(1) << lowest_free(16'(after_exit), NUM_SLOTS) : '0;
      spots_n    = after_exit | entry_mask[NUM_SLOTS-1:0];
      capacity_n = capacity + CAP_W'(exit_ok) - CAP_W'(entry_ok);
      state_n    = capacity_n == CAP_W'(NUM_SLOTS) ? EMPTY : capacity_n == '0 ? FULL : PARTIAL;
      t_sel      = '0;
      for (int j = 0; j < NUM_SLOTS; j++) if (SLOT_W'(j) == exit_slot) t_sel = timers[j];
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= EMPTY;
      else state <= state_n;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         spots        <= '0;
         capacity     <= CAP_W'(NUM_SLOTS);
         location     <= '0;
         loc_valid    <= 1'b1;
         is_open      <= 1'b0;
         is_full      <= 1'b0;
         exit_err     <= 1'b0;
         exit_valid   <= 1'b0;
         exit_minutes <= '0;
         exit_seconds <= '0;
      end else begin
         spots      <= spots_n;
         capacity   <= capacity_n;
         location   <= SLOT_W'(lowest_free(16'(spots_n), NUM_SLOTS));
         loc_valid  <= ~&spots_n;
         is_open    <= entry_ok | exit_ok;
         is_full    <= entry_signal & ~has_free;
         exit_err   <= exit_signal & ~exit_ok;
         exit_valid <= exit_ok;
         if (exit_ok) begin
            exit_minutes <= 6'(32'(t_sel) / SECS_PER_MIN);
            exit_seconds <= 6'(32'(t_sel) % SECS_PER_MIN);
         end
      end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_timer #(.MAX_SECONDS(MAX_SECONDS), .W(TW)) u_timer (
         .clk      (clk),
         .reset    (reset),
         .tick_1hz (tick_1hz),
         .occupied (spots[i]),
         .clear    (entry_mask[i] | exit_mask[i]),
         .count    (timers[i])
      );
   end
endmodule

// File: tb/tb_parking_manager.sv
// tb_parking_manager: directed plus random stimulus checked against a slot-array reference model.
module tb_parking_manager;
   import parking_pkg::*;
   localparam int N    = 4;
   localparam int MAXS = 3599;
   logic clk = 0, reset = 1, tick_1hz = 0, entry_signal = 0, exit_signal = 0;
   logic [1:0] exit_slot = 0;
   logic is_open, is_full, exit_err, loc_valid, exit_valid;
   logic [3:0] spots;
   logic [2:0] capacity;
   logic [1:0] location;
   logic [5:0] exit_minutes, exit_seconds;
   logic e5_entry = 0, e5_exit = 0;
   logic [2:0] e5_slot = 0;
   logic o5_open, o5_full, o5_err, o5_lv, o5_ev;
   logic [4:0] o5_spots;
   logic [2:0] o5_cap, o5_loc;
   logic [5:0] o5_min, o5_sec;
   int errors = 0, checks = 0;
   bit occ [N];
   int tm [N];
   int e_min, e_sec;
   bit x_open, x_full, x_err, x_valid;

   always #5 clk = ~clk;

   parking_manager #(.NUM_SLOTS(N), .MAX_SECONDS(MAXS)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .entry_signal(entry_signal),
      .exit_signal(exit_signal), .exit_slot(exit_slot), .is_open(is_open), .is_full(is_full),
      .exit_err(exit_err), .spots(spots), .capacity(capacity), .location(location),
      .loc_valid(loc_valid), .exit_valid(exit_valid), .exit_minutes(exit_minutes),
      .exit_seconds(exit_seconds)
   );

   // Five-slot variant: 3-bit slot index, so out-of-range exits are expressible.
   parking_manager #(.NUM_SLOTS(5), .MAX_SECONDS(MAXS)) dut5 (
      .clk(clk), .reset(reset), .tick_1hz(1'b0), .entry_signal(e5_entry),
      .exit_signal(e5_exit), .exit_slot(e5_slot), .is_open(o5_open), .is_full(o5_full),
      .exit_err(o5_err), .spots(o5_spots), .capacity(o5_cap), .location(o5_loc),
      .loc_valid(o5_lv), .exit_valid(o5_ev), .exit_minutes(o5_min), .exit_seconds(o5_sec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         occ[i] = 0;
         tm[i]  = 0;
      end
      e_min = 0; e_sec = 0;
      x_open = 0; x_full = 0; x_err = 0; x_valid = 0;
   endtask

   task automatic check_all(input string ctx);
      int free = 0, loc = 0;
      logic [3:0] sp = 0;
      state_t st;
      for (int i = N - 1; i >= 0; i--) begin
         sp[i] = occ[i];
         if (!occ[i]) begin
            free++;
            loc = i;
         end
      end
      st = free == N ? EMPTY : free == 0 ? FULL : PARTIAL;
      check({ctx, ":spots"}, 32'(spots), 32'(sp));
      check({ctx, ":capacity"}, 32'(capacity), 32'(free));
      check({ctx, ":location"}, 32'(location), 32'(loc));
      check({ctx, ":loc_valid"}, 32'(loc_valid), 32'(free > 0));
      check({ctx, ":is_open"}, 32'(is_open), 32'(x_open));
      check({ctx, ":is_full"}, 32'(is_full), 32'(x_full));
      check({ctx, ":exit_err"}, 32'(exit_err), 32'(x_err));
      check({ctx, ":exit_valid"}, 32'(exit_valid), 32'(x_valid));
      check({ctx, ":exit_minutes"}, 32'(exit_minutes), 32'(e_min));
      check({ctx, ":exit_seconds"}, 32'(exit_seconds), 32'(e_sec));
      check({ctx, ":state"}, 32'(dut.state), 32'(st));
   endtask

   task automatic step(input bit en, input bit ex, input int sl, input bit tk, input string ctx);
      int ent = -1;
      @(negedge clk);
      entry_signal = en; exit_signal = ex; exit_slot = 2'(sl); tick_1hz = tk;
      @(posedge clk);
      x_open = 0; x_full = 0; x_err = 0; x_valid = 0;
      if (ex && sl < N && occ[sl]) begin
         x_valid = 1; x_open = 1;
         e_min = tm[sl] / 60;
         e_sec = tm[sl] % 60;
      end else if (ex) x_err = 1;
      if (tk) for (int i = 0; i < N; i++) if (occ[i] && tm[i] < MAXS) tm[i]++;
      if (x_valid) begin
         occ[sl] = 0;
         tm[sl]  = 0;
      end
      if (en) begin
         for (int i = N - 1; i >= 0; i--) if (!occ[i]) ent = i;
         if (ent < 0) x_full = 1;
         else begin
            occ[ent] = 1; tm[ent] = 0; x_open = 1;
         end
      end
      #1;
      entry_signal = 0; exit_signal = 0; tick_1hz = 0;
      check_all(ctx);
   endtask

   task automatic step5(input bit en, input bit ex, input int sl);
      @(negedge clk);
      e5_entry = en; e5_exit = ex; e5_slot = 3'(sl);
      @(posedge clk);
      #1;
      e5_entry = 0; e5_exit = 0;
   endtask

   initial begin
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_all("rst");
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, "fill");
      step(1, 0, 0, 0, "entry_when_full");
      step(0, 1, 2, 0, "exit2");
      check("exit2_location", 32'(location), 32'(2));
      step(1, 0, 0, 0, "refill2");
      step(0, 1, 0, 0, "exit0");
      step(1, 0, 0, 0, "enter0");
      repeat (75) step(0, 0, 0, 1, "tick75");
      step(0, 1, 0, 0, "exit0_75");
      check("stay75_min", 32'(exit_minutes), 32'(1));
      check("stay75_sec", 32'(exit_seconds), 32'(15));
      step(1, 0, 0, 0, "enter0b");
      step(1, 1, 1, 0, "swap1");
      check("swap_capacity", 32'(capacity), 32'(0));
      check("swap_no_full", 32'(is_full), 32'(0));
      repeat (3) step(0, 0, 0, 1, "tick3");
      step(0, 1, 1, 0, "exit1");
      check("new_slot1_sec", 32'(exit_seconds), 32'(3));
      step(0, 1, 3, 0, "exit3");
      step(0, 1, 3, 0, "exit3_empty");
      check("empty_exit_err", 32'(exit_err), 32'(1));
      repeat (MAXS + 10) step(0, 0, 0, 1, "tick_sat");
      step(0, 1, 0, 0, "exit_sat");
      check("sat_min", 32'(exit_minutes), 32'(59));
      check("sat_sec", 32'(exit_seconds), 32'(59));
      @(negedge clk);
      #2 reset = 1;
      #1;
      reset_model();
      check_all("async_rst");
      check("async_rst_d5_cap", 32'(o5_cap), 32'(5));
      @(negedge clk);
      reset = 0;
      repeat (400)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), "rand");
      step5(0, 1, 5);
      check("d5_err5", 32'(o5_err), 32'(1));
      check("d5_open5", 32'(o5_open), 32'(0));
      check("d5_cap5", 32'(o5_cap), 32'(5));
      check("d5_spots5", 32'(o5_spots), 32'(0));
      check("d5_state5", 32'(dut5.state), 32'(EMPTY));
      step5(1, 0, 0);
      check("d5_enter_spots", 32'(o5_spots), 32'(1));
      check("d5_enter_cap", 32'(o5_cap), 32'(4));
      check("d5_enter_loc", 32'(o5_loc), 32'(1));
      step5(0, 1, 7);
      check("d5_err7", 32'(o5_err), 32'(1));
      check("d5_valid7", 32'(o5_ev), 32'(0));
      check("d5_spots7", 32'(o5_spots), 32'(1));
      check("d5_cap7", 32'(o5_cap), 32'(4));
      check("d5_state7", 32'(dut5.state), 32'(PARTIAL));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
